// File: rtl/plat_layout_loader.sv
// Follows the character's vertical block and reloads that block's platform table from ROM into a shadow bank, then commits it atomically.
// A commit is visible PLAT_NUM+3 cycles after a crossing; there is no backpressure, and y is sampled only in IDLE with one block moved per load.
module plat_layout_loader #(
    parameter int BLOCK_NUM    = 7,
    parameter int PLAT_NUM     = 7,
    parameter int PHY_WIDTH    = 14,
    parameter int LEN_WIDTH    = 4,
    parameter int BLOCK_HEIGHT = 480,
    parameter int IDX_WIDTH    = 5,
    parameter int HYST         = 8,
    parameter int ROM_AW       = $clog2(BLOCK_NUM*PLAT_NUM)
) (
    input  logic                                 sys_clk,
    input  logic                                 sys_rst_n,
    input  logic [PHY_WIDTH-1:0]                 abs_char_y,
    output logic [ROM_AW-1:0]                    rom_addr,
    input  logic [2*PHY_WIDTH+LEN_WIDTH-1:0]     rom_data,
    output logic [IDX_WIDTH-1:0]                 block_idx,
    output logic [$clog2(BLOCK_NUM)-1:0]         block_type,
    output logic [PLAT_NUM*PHY_WIDTH-1:0]        plat_x,
    output logic [PLAT_NUM*PHY_WIDTH-1:0]        plat_y,
    output logic [PLAT_NUM*LEN_WIDTH-1:0]        plat_len,
    output logic                                 layout_valid,
    output logic                                 busy,
    output logic                                 block_switch,
    output logic                                 switch_up
);
    localparam int TYPE_W = $clog2(BLOCK_NUM);
    localparam int CNT_W  = $clog2(PLAT_NUM + 1);
    localparam int CW     = PHY_WIDTH + 1;
    localparam logic [CW-1:0]        BH_EXT   = CW'(BLOCK_HEIGHT);
    localparam logic [CW-1:0]        HYST_EXT = CW'(HYST);
    localparam logic [PHY_WIDTH-1:0] BH       = PHY_WIDTH'(BLOCK_HEIGHT);
    localparam logic [TYPE_W-1:0]    TYPE_MAX = TYPE_W'(BLOCK_NUM - 1);
    localparam logic [ROM_AW-1:0]    PN_A     = ROM_AW'(PLAT_NUM);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_COMMIT} state_t;

    state_t                        state;
    logic [IDX_WIDTH-1:0]          t_idx;
    logic [TYPE_W-1:0]             t_type;
    logic [PHY_WIDTH-1:0]          t_base;
    logic                          t_up;
    logic [CNT_W-1:0]              cnt;
    logic [PLAT_NUM*PHY_WIDTH-1:0] sh_x;
    logic [PLAT_NUM*PHY_WIDTH-1:0] sh_y;
    logic [PLAT_NUM*LEN_WIDTH-1:0] sh_len;

    logic [CW-1:0]     y_ext;
    logic [CW-1:0]     base_ext;
    logic              want_up;
    logic              want_dn;
    logic [TYPE_W-1:0] type_up;
    logic [TYPE_W-1:0] type_dn;

    // One extra bit keeps base+height and y+hysteresis from wrapping.
    always_comb begin
        y_ext    = {1'b0, abs_char_y};
        base_ext = {1'b0, t_base};
        want_up  = (y_ext >= base_ext + BH_EXT) && (t_idx != '1);
        want_dn  = (t_idx != '0) && (y_ext + HYST_EXT < base_ext);
        type_up  = (t_type == TYPE_MAX) ? '0 : t_type + 1'b1;
        type_dn  = (t_type == '0) ? TYPE_MAX : t_type - 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= S_IDLE;
            t_idx        <= '0;
            t_type       <= '0;
            t_base       <= '0;
            t_up         <= 1'b0;
            cnt          <= '0;
            sh_x         <= '0;
            sh_y         <= '0;
            sh_len       <= '0;
            rom_addr     <= '0;
            block_idx    <= '0;
            block_type   <= '0;
            plat_x       <= '0;
            plat_y       <= '0;
            plat_len     <= '0;
            layout_valid <= 1'b0;
            busy         <= 1'b0;
            block_switch <= 1'b0;
            switch_up    <= 1'b0;
        end else begin
            block_switch <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Nothing committed yet: load type 0 without moving the targets.
                    if (!layout_valid) begin
                        cnt      <= '0;
                        rom_addr <= '0;
                        busy     <= 1'b1;
                        state    <= S_FETCH;
                    end else if (want_up) begin
                        t_idx    <= t_idx + 1'b1;
                        t_type   <= type_up;
                        t_base   <= t_base + BH;
                        t_up     <= 1'b1;
                        cnt      <= '0;
                        rom_addr <= ROM_AW'(type_up) * PN_A;
                        busy     <= 1'b1;
                        state    <= S_FETCH;
                    end else if (want_dn) begin
                        t_idx    <= t_idx - 1'b1;
                        t_type   <= type_dn;
                        t_base   <= t_base - BH;
                        t_up     <= 1'b0;
                        cnt      <= '0;
                        rom_addr <= ROM_AW'(type_dn) * PN_A;
                        busy     <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // ROM data trails its address by one cycle, so slot k fills when cnt == k+1.
                    for (int k = 0; k < PLAT_NUM; k++) begin
                        if (cnt == CNT_W'(k + 1)) begin
                            sh_x[k*PHY_WIDTH +: PHY_WIDTH]   <= rom_data[LEN_WIDTH+PHY_WIDTH +: PHY_WIDTH];
                            sh_y[k*PHY_WIDTH +: PHY_WIDTH]   <= rom_data[LEN_WIDTH +: PHY_WIDTH];
                            sh_len[k*LEN_WIDTH +: LEN_WIDTH] <= rom_data[0 +: LEN_WIDTH];
                        end
                    end
                    if (cnt < CNT_W'(PLAT_NUM - 1)) begin
                        rom_addr <= rom_addr + 1'b1;
                    end
                    if (cnt == CNT_W'(PLAT_NUM)) begin
                        state <= S_COMMIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_COMMIT: begin
                    plat_x       <= sh_x;
                    plat_y       <= sh_y;
                    plat_len     <= sh_len;
                    block_idx    <= t_idx;
                    block_type   <= t_type;
                    layout_valid <= 1'b1;
                    if (layout_valid) begin
                        block_switch <= 1'b1;
                        switch_up    <= t_up;
                    end
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/plat_layout_loader.md
# plat_layout_loader

Parametrised successor to the per-block platform generator. It tracks which vertical block the character occupies and streams that block's platform table out of an external synchronous ROM into a shadow bank. It then atomically commits the table to flat platform buses consumed by the collision and VGA render logic. Block-boundary crossings use hysteresis, and the block type wraps modulo `BLOCK_NUM`, so arbitrarily tall levels reuse a fixed layout ROM.

## Interface
- `BLOCK_NUM`, 7: distinct layouts in ROM; block type = block index mod `BLOCK_NUM`.
- `PLAT_NUM`, 7: platforms per block.
- `PHY_WIDTH`, 14: coordinate width.
- `LEN_WIDTH`, 4: platform length width.
- `BLOCK_HEIGHT`, 480: block height in pixels.
- `IDX_WIDTH`, 5: block index width; index saturates at 2^`IDX_WIDTH`-1.
- `HYST`, 8: downward-crossing hysteresis in pixels.
- `ROM_AW`, `$clog2(BLOCK_NUM*PLAT_NUM)`: ROM address width.

Ports:
- `sys_clk` in 1: clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `abs_char_y` in `PHY_WIDTH`: absolute character y.
- `rom_addr` out `ROM_AW`: ROM address = `type*PLAT_NUM + k`.
- `rom_data` in `2*PHY_WIDTH+LEN_WIDTH`: `{x, y, len}`. Data is valid exactly 1 cycle after its address.
- `block_idx` out `IDX_WIDTH`: committed block index (camera).
- `block_type` out `$clog2(BLOCK_NUM)`: committed layout type.
- `plat_x` out `PLAT_NUM*PHY_WIDTH`: platform k occupies slice `[k*PHY_WIDTH +: PHY_WIDTH]`.
- `plat_y` out `PLAT_NUM*PHY_WIDTH`: same packing as `plat_x`.
- `plat_len` out `PLAT_NUM*LEN_WIDTH`: same packing, slice width `LEN_WIDTH`.
- `layout_valid` out 1: at least one commit has occurred since reset.
- `busy` out 1: high in FETCH or COMMIT.
- `block_switch` out 1: one-cycle pulse on each non-initial commit.
- `switch_up` out 1: direction of the last committed switch (1 = up).

## Operation
- Internal target registers:
  - `t_idx`, `t_type`, and `t_base` (= `t_idx*BLOCK_HEIGHT`).
  - These are maintained incrementally, with no divider:
    - Step up: `t_base += BLOCK_HEIGHT`, `t_type` wraps `BLOCK_NUM-1` → 0.
    - Step down: `t_base -= BLOCK_HEIGHT`, `t_type` wraps 0 → `BLOCK_NUM-1`.
- States:
  - IDLE:
    - Step up if `abs_char_y >= t_base + BLOCK_HEIGHT` and `t_idx` is not at max.
    - Otherwise step down if `t_idx != 0` and `abs_char_y + HYST < t_base`.
    - Up has priority.
    - On a step: update the targets, clear k, go to FETCH.
    - Comparisons use `PHY_WIDTH+1` bits so they cannot overflow.
  - FETCH:
    - Issue `rom_addr = t_type*PLAT_NUM + k` for k = 0..`PLAT_NUM`-1, one per cycle.
    - Capture `rom_data` into shadow slot k-1 on the following cycle.
    - The state lasts `PLAT_NUM+1` cycles (last cycle is a drain), then goes to COMMIT.
  - COMMIT (1 cycle):
    - Copy the shadow bank, `t_idx` and `t_type` to the outputs in the same edge.
    - Set `layout_valid` = 1.
    - Pulse `block_switch` and load `switch_up` unless this is the initial load.
    - Return to IDLE.
- Reset:
  - All outputs are 0, `rom_addr` is 0, targets are 0.
  - After release, the FSM enters FETCH for type 0 (initial load, no `block_switch` pulse).
- `abs_char_y` is sampled only in IDLE; changes during FETCH/COMMIT are ignored until the return to IDLE.
- Multi-block moves proceed one block per load. Each load commits and pulses `block_switch`.
- `rom_addr` holds its last value when not in FETCH.

## Timing
- Crossing condition first true in IDLE at cycle T:
  - FETCH occupies T+1..T+`PLAT_NUM`+1.
  - COMMIT is at T+`PLAT_NUM`+2.
  - New outputs and the `block_switch` pulse are visible at T+`PLAT_NUM`+3 (T+10 for defaults).
- Minimum spacing between successive commits: `PLAT_NUM`+3 cycles.
- Plat buses, `block_idx`, `block_type` and `switch_up` change only in the COMMIT edge, never partially.
- After reset release (first edge R): `layout_valid` rises at R+`PLAT_NUM`+2.
- Reset asserted mid-FETCH: immediate clear of all outputs; the initial load restarts on release.

## Test plan
- Reset, ROM entry 0 = {120, 60, 10}, hold `abs_char_y`=0 → `layout_valid`=1 at R+9, `block_idx`=0, `plat_x[0]`=120, `plat_y[0]`=60, `plat_len[0]`=10, no `block_switch` pulse.
- `abs_char_y` 0→480 at T → `block_switch` pulse at T+10, `block_idx`=1, `block_type`=1, `switch_up`=1, buses equal ROM entries 7..13; `busy` high T+1..T+9.
- Hysteresis, from block 1:
  - y=475 or y=472 → no step.
  - y=471 → commit to `block_idx`=0 with `switch_up`=0.
- Wrap: climb to y=3360 → `block_idx`=7, `block_type`=0, ROM addresses 0..6 fetched. Descending from idx 7 to 6 gives `block_type`=6.
- Fall from y=1500 (idx 3) to y=10 in one cycle → three commits 10 cycles apart (idx 2, 1, 0), each with a `block_switch` pulse and `switch_up`=0. Toggling y during FETCH does not alter the fetched addresses.
- Assert `sys_rst_n` at FETCH k=3 → outputs 0 immediately; after release, a clean initial load of type 0 with `layout_valid` at R+9.
